// File: rtl/stream_to_axi_b_if.sv
// Bundles the inbound snoop stream and the replayed AXI4 B channel.
// The master modport is the stream source / AXI master side; slave is the bridge.
interface stream_to_axi_b_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 32,
    parameter int USER_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;
    logic [ID_WIDTH-1:0]   AXIS_bid;
    logic [1:0]            AXIS_bresp;
    logic [USER_WIDTH-1:0] AXIS_buser;
    logic                  AXIS_bvalid;
    logic                  AXIS_bready;

    modport master (
        output in_data, in_valid, in_last, AXIS_bready,
        input  in_ready, AXIS_bid, AXIS_bresp, AXIS_buser, AXIS_bvalid
    );

    modport slave (
        input  in_data, in_valid, in_last, AXIS_bready,
        output in_ready, AXIS_bid, AXIS_bresp, AXIS_buser, AXIS_bvalid
    );
endinterface

// File: rtl/stream_to_axi_b.sv
// Replays B-channel records received over the snoop stream as AXI4 B handshakes.
// Records are buffered in a small FIFO; foreign or multi-beat packets are discarded and counted.
module stream_to_axi_b #(
    parameter int                             DATA_WIDTH        = 128,
    parameter int                             ID_WIDTH          = 32,
    parameter int                             USER_WIDTH        = 64,
    parameter int                             STREAM_TYPE_WIDTH = 3,
    parameter logic [STREAM_TYPE_WIDTH-1:0]   STREAM_TYPE       = 3'b100,
    parameter int                             FIFO_DEPTH        = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    stream_to_axi_b_if.slave              bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          type_error,
    output logic [15:0]                   drop_count
);
    localparam int              PW         = $clog2(FIFO_DEPTH);
    localparam int              LW         = PW + 1;
    localparam int              RW         = ID_WIDTH + 2;
    localparam logic [LW-1:0]   FULL_LEVEL = LW'(FIFO_DEPTH);

    typedef enum logic {HEADER, DISCARD} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic            in_ready_q, in_ready_d;
    logic            bvalid_q, bvalid_d;
    logic            type_error_q;
    logic [15:0]     drop_q;
    logic [RW-1:0]   mem_q [FIFO_DEPTH];
    logic [RW-1:0]   head;

    logic [STREAM_TYPE_WIDTH-1:0] hdr_type;
    logic [ID_WIDTH-1:0]          hdr_bid;
    logic [1:0]                   hdr_bresp;
    logic                         hdr_ok, accept, push, pop, drop;
    logic                         unused_data;

    assign hdr_type    = bus.in_data[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH];
    assign hdr_bid     = bus.in_data[DATA_WIDTH-STREAM_TYPE_WIDTH-1 -: ID_WIDTH];
    assign hdr_bresp   = bus.in_data[1:0];
    assign unused_data = ^bus.in_data;

    assign hdr_ok = (hdr_type == STREAM_TYPE) && bus.in_last;
    assign accept = bus.in_valid && in_ready_q;
    assign push   = accept && (state_q == HEADER) && hdr_ok;
    assign drop   = accept && (state_q == HEADER) && !hdr_ok;
    assign pop    = bvalid_q && bus.AXIS_bready;

    // in_ready/bvalid are registered from next-state values, so neither
    // in_data nor AXIS_bready has a combinational path to an output.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HEADER:  if (drop && !bus.in_last)   state_d = DISCARD;
            DISCARD: if (accept && bus.in_last)  state_d = HEADER;
            default:                             state_d = HEADER;
        endcase

        level_d = level_q;
        if (push && !pop)
            level_d = level_q + 1'b1;
        else if (pop && !push)
            level_d = level_q - 1'b1;

        bvalid_d   = (level_d != '0);
        in_ready_d = (state_d == DISCARD) || (level_d != FULL_LEVEL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HEADER;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            in_ready_q   <= 1'b0;
            bvalid_q     <= 1'b0;
            type_error_q <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            in_ready_q   <= in_ready_d;
            bvalid_q     <= bvalid_d;
            type_error_q <= drop;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop && (drop_q != 16'hFFFF))
                drop_q <= drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {hdr_bid, hdr_bresp};
    end

    assign head            = mem_q[rd_ptr_q];
    assign bus.in_ready    = in_ready_q;
    assign bus.AXIS_bvalid = bvalid_q;
    assign bus.AXIS_bid    = head[RW-1:2];
    assign bus.AXIS_bresp  = head[1:0];
    assign bus.AXIS_buser  = '0;
    assign fifo_level      = level_q;
    assign type_error      = type_error_q;
    assign drop_count      = drop_q;
endmodule

// File: tb/tb_stream_to_axi_b.sv
// Directed plus randomized bench for stream_to_axi_b against a packet-level record queue model.
module tb_stream_to_axi_b;
    localparam int DW    = 128;
    localparam int IDW   = 32;
    localparam int UW    = 64;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  fifo_level;
    logic        type_error;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    logic [33:0] q[$];
    logic        in_discard = 1'b0;
    int          mdrop      = 0;
    logic        prev_bad   = 1'b0;

    stream_to_axi_b_if #(.DATA_WIDTH(DW), .ID_WIDTH(IDW), .USER_WIDTH(UW)) bus_if ();

    stream_to_axi_b #(
        .DATA_WIDTH(DW), .ID_WIDTH(IDW), .USER_WIDTH(UW),
        .STREAM_TYPE_WIDTH(3), .STREAM_TYPE(3'b100), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if),
        .fifo_level (fifo_level),
        .type_error (type_error),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [2:0] t, input logic [31:0] id, input logic [1:0] r);
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        d[127:125] = t;
        d[124:93]  = id;
        d[1:0]     = r;
        return d;
    endfunction

    // One clock cycle: check outputs against the model, drive inputs, advance the model.
    task automatic cycle(input logic v, input logic [127:0] d, input logic l, input logic br,
                         output logic acc);
        logic exp_rdy, exp_bv, bad_now;
        bus_if.in_valid    = v;
        bus_if.in_data     = d;
        bus_if.in_last     = l;
        bus_if.AXIS_bready = br;
        exp_rdy = in_discard || (q.size() < DEPTH);
        exp_bv  = (q.size() != 0);
        chk("in_ready",   64'(bus_if.in_ready),    64'(exp_rdy));
        chk("bvalid",     64'(bus_if.AXIS_bvalid), 64'(exp_bv));
        if (exp_bv) begin
            chk("bid",   64'(bus_if.AXIS_bid),   64'(q[0][33:2]));
            chk("bresp", 64'(bus_if.AXIS_bresp), 64'(q[0][1:0]));
        end
        chk("fifo_level", 64'(fifo_level), 64'(q.size()));
        chk("type_error", 64'(type_error), 64'(prev_bad));
        chk("drop_count", 64'(drop_count), 64'(mdrop));
        acc     = v && exp_rdy;
        bad_now = 1'b0;
        if (exp_bv && br)
            void'(q.pop_front());
        if (acc) begin
            if (!in_discard) begin
                if (d[127:125] == 3'b100 && l) begin
                    q.push_back({d[124:93], d[1:0]});
                end else begin
                    bad_now = 1'b1;
                    if (mdrop < 65535) mdrop++;
                    in_discard = !l;
                end
            end else if (l) begin
                in_discard = 1'b0;
            end
        end
        prev_bad = bad_now;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [127:0] d, input logic l, input logic br);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 64) begin
            cycle(1'b1, d, l, br, acc);
            n++;
        end
        if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n, input logic br);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, br, acc);
    endtask

    task automatic do_reset(input int n);
        reset              = 1'b1;
        bus_if.in_valid    = 1'b0;
        bus_if.in_last     = 1'b0;
        bus_if.in_data     = '0;
        bus_if.AXIS_bready = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",   64'(bus_if.in_ready),    64'd0);
        chk("rst_bvalid",     64'(bus_if.AXIS_bvalid), 64'd0);
        chk("rst_level",      64'(fifo_level),         64'd0);
        chk("rst_type_error", 64'(type_error),         64'd0);
        chk("rst_drop_count", 64'(drop_count),         64'd0);
        chk("buser",          64'(bus_if.AXIS_buser),  64'd0);
        q.delete();
        in_discard = 1'b0;
        mdrop      = 0;
        prev_bad   = 1'b0;
        reset      = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic acc;
        logic [2:0] t;
        do_reset(3);

        // single record, immediate handshake
        send(mk(3'b100, 32'hA5, 2'b10), 1'b1, 1'b1);
        chk("lat_bvalid", 64'(bus_if.AXIS_bvalid), 64'd1);
        chk("lat_bid",    64'(bus_if.AXIS_bid),    64'hA5);
        idle(3, 1'b1);

        // fill to full with bready low, fifth stalls, then drain in order
        for (int i = 0; i < 4; i++)
            send(mk(3'b100, 32'h100 + i, 2'(i)), 1'b1, 1'b0);
        idle(2, 1'b0);
        chk("full_level", 64'(fifo_level),      64'd4);
        chk("full_ready", 64'(bus_if.in_ready), 64'd0);
        send(mk(3'b100, 32'h104, 2'b00), 1'b1, 1'b1);
        idle(6, 1'b1);

        // foreign type, single beat
        send(mk(3'b001, 32'h77, 2'b01), 1'b1, 1'b1);
        idle(2, 1'b1);

        // three-beat packet discarded, then a good record
        send(mk(3'b100, 32'h55, 2'b11), 1'b0, 1'b1);
        send(mk(3'b010, 32'h0,  2'b00), 1'b0, 1'b1);
        send(mk(3'b100, 32'h66, 2'b01), 1'b1, 1'b1);
        send(mk(3'b100, 32'hBEEF, 2'b01), 1'b1, 1'b1);
        idle(3, 1'b1);

        // reset with two records pending
        send(mk(3'b100, 32'h1, 2'b01), 1'b1, 1'b0);
        send(mk(3'b100, 32'h2, 2'b10), 1'b1, 1'b0);
        idle(1, 1'b0);
        do_reset(1);
        idle(2, 1'b1);

        // randomized stall soak
        for (int i = 0; i < 3000; i++) begin
            t = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b100;
            cycle(($urandom_range(0, 3) != 0), mk(t, $urandom, 2'($urandom)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), acc);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(3'b100, $urandom, 2'b00), 1'b1, 1'b1, acc);
        idle(10, 1'b1);
        chk("soak_drained", 64'(q.size()), 64'd0);

        // drop counter saturation
        for (int i = 0; i < 65540; i++)
            cycle(1'b1, mk(3'b011, $urandom, 2'b00), 1'b1, 1'b0, acc);
        idle(2, 1'b0);
        chk("drop_sat", 64'(drop_count), 64'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
